ioctl_rom_loader: RTL and testbench

IOCTL_ROM_LOADER -- requirements
Module: ioctl_rom_loader

---
 rtl/ioctl_rom_loader.sv | 167 ++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_loader.sv
// rtl/ioctl_rom_loader.sv - packs HPS ioctl download bytes into 16-bit big-endian SDRAM write requests
module ioctl_rom_loader #(
  parameter logic [15:0] ROM_INDEX = 16'd0,
  parameter int          ADDR_W    = 24
) (
  input  logic              i_EMU_MCLK,
  input  logic              i_EMU_INITRST,
  input  logic              ioctl_download,
  input  logic [15:0]       ioctl_index,
  input  logic              ioctl_wr,
  input  logic [26:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic              o_MEM_REQ,
  output logic [ADDR_W-2:0] o_MEM_ADDR,
  output logic [15:0]       o_MEM_DATA,
  output logic [1:0]        o_MEM_BE,
  input  logic              i_MEM_ACK,
  output logic              o_LOADING,
  output logic              o_DONE,
  output logic              o_ERR
);

  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FLUSH, DONE} state_t;
  state_t state;

  logic              held_valid;
  logic [ADDR_W-2:0] held_addr;
  logic [7:0]        held_data;
  logic              pend_valid;
  logic              pend_odd;
  logic [ADDR_W-2:0] pend_addr;
  logic [7:0]        pend_data;

  logic              start_match;
  logic [ADDR_W-2:0] wr_word;
  logic              wr_odd;
  logic              wr_in_range;

  assign start_match = ioctl_download && (ioctl_index == ROM_INDEX);
  assign wr_word     = ioctl_addr[ADDR_W-1:1];
  assign wr_odd      = ioctl_addr[0];
  assign wr_in_range = (ioctl_addr >> ADDR_W) == 27'd0;

  always_ff @(posedge i_EMU_MCLK) begin
    if (i_EMU_INITRST) begin
      state      <= IDLE;
      ioctl_wait <= 1'b0;
      o_MEM_REQ  <= 1'b0;
      o_MEM_ADDR <= '0;
      o_MEM_DATA <= 16'h0000;
      o_MEM_BE   <= 2'b00;
      o_LOADING  <= 1'b0;
      o_DONE     <= 1'b0;
      o_ERR      <= 1'b0;
      held_valid <= 1'b0;
      held_addr  <= '0;
      held_data  <= 8'h00;
      pend_valid <= 1'b0;
      pend_odd   <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= 8'h00;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_match) begin
            state      <= COLLECT;
            o_LOADING  <= 1'b1;
            o_DONE     <= 1'b0;
            o_ERR      <= 1'b0;
            held_valid <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        COLLECT: begin
          if (!ioctl_download) begin
            if (held_valid) begin
              state      <= FLUSH;
              o_MEM_REQ  <= 1'b1;
              ioctl_wait <= 1'b1;
              o_MEM_ADDR <= held_addr;
              o_MEM_DATA <= {held_data, 8'h00};
              o_MEM_BE   <= 2'b10;
              held_valid <= 1'b0;
            end else begin
              state     <= DONE;
              o_LOADING <= 1'b0;
              o_DONE    <= 1'b1;
            end
          end else if (ioctl_wr) begin
            if (!wr_in_range) begin
              o_ERR <= 1'b1;
            end else if (held_valid && held_addr != wr_word) begin
              // Orphaned even byte goes out first; the new byte waits in pend_*.
              state      <= WRITE;
              o_MEM_REQ  <= 1'b1;
              ioctl_wait <= 1'b1;
              o_MEM_ADDR <= held_addr;
              o_MEM_DATA <= {held_data, 8'h00};
              o_MEM_BE   <= 2'b10;
              held_valid <= 1'b0;
              pend_valid <= 1'b1;
              pend_odd   <= wr_odd;
              pend_addr  <= wr_word;
              pend_data  <= ioctl_data;
            end else if (!wr_odd) begin
              held_valid <= 1'b1;
              held_addr  <= wr_word;
              held_data  <= ioctl_data;
            end else begin
              state      <= WRITE;
              o_MEM_REQ  <= 1'b1;
              ioctl_wait <= 1'b1;
              o_MEM_ADDR <= wr_word;
              o_MEM_DATA <= {(held_valid ? held_data : 8'h00), ioctl_data};
              o_MEM_BE   <= held_valid ? 2'b11 : 2'b01;
              held_valid <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (ioctl_wr) o_ERR <= 1'b1;
          if (i_MEM_ACK) begin
            pend_valid <= 1'b0;
            if (pend_valid && pend_odd) begin
              o_MEM_ADDR <= pend_addr;
              o_MEM_DATA <= {8'h00, pend_data};
              o_MEM_BE   <= 2'b01;
            end else if (ioctl_download) begin
              state      <= COLLECT;
              o_MEM_REQ  <= 1'b0;
              ioctl_wait <= 1'b0;
              if (pend_valid) begin
                held_valid <= 1'b1;
                held_addr  <= pend_addr;
                held_data  <= pend_data;
              end
            end else if (pend_valid) begin
              state      <= FLUSH;
              o_MEM_ADDR <= pend_addr;
              o_MEM_DATA <= {pend_data, 8'h00};
              o_MEM_BE   <= 2'b10;
            end else begin
              state      <= DONE;
              o_MEM_REQ  <= 1'b0;
              ioctl_wait <= 1'b0;
              o_LOADING  <= 1'b0;
              o_DONE     <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (ioctl_wr) o_ERR <= 1'b1;
          if (i_MEM_ACK) begin
            state      <= DONE;
            o_MEM_REQ  <= 1'b0;
            ioctl_wait <= 1'b0;
            o_LOADING  <= 1'b0;
            o_DONE     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ioctl_rom_loader.sv
// tb/tb_ioctl_rom_loader.sv - self-checking bench for ioctl_rom_loader
module tb_ioctl_rom_loader;
  localparam int ADDR_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              ioctl_download;
  logic [15:0]       ioctl_index;
  logic              ioctl_wr;
  logic [26:0]       ioctl_addr;
  logic [7:0]        ioctl_data;
  logic              ioctl_wait;
  logic              mem_req;
  logic [ADDR_W-2:0] mem_addr;
  logic [15:0]       mem_data;
  logic [1:0]        mem_be;
  logic              mem_ack;
  logic              loading;
  logic              done;
  logic              err;

  typedef struct packed {
    logic [ADDR_W-2:0] addr;
    logic [15:0]       data;
    logic [1:0]        be;
  } wr_t;

  wr_t got_q[$];
  int  checks = 0;
  int  errors = 0;
  int  ack_delay = 0;
  bit  ack_en = 1'b1;
  int  stab_viol = 0;

  always #5 clk = ~clk;

  ioctl_rom_loader #(.ROM_INDEX(16'd0), .ADDR_W(ADDR_W)) dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
    .ioctl_wait(ioctl_wait),
    .o_MEM_REQ(mem_req), .o_MEM_ADDR(mem_addr), .o_MEM_DATA(mem_data), .o_MEM_BE(mem_be),
    .i_MEM_ACK(mem_ack),
    .o_LOADING(loading), .o_DONE(done), .o_ERR(err)
  );

  // SDRAM side: acks after ack_delay cycles, records accepted writes, watches stability
  initial begin
    int  cnt;
    bit  active;
    wr_t cur;
    cnt = 0; active = 0; cur = '0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_ack) begin mem_ack = 1'b0; active = 0; cnt = 0; end
      if (mem_req && !rst) begin
        if (active && cur != {mem_addr, mem_data, mem_be}) stab_viol++;
        if (!active) begin cur = {mem_addr, mem_data, mem_be}; active = 1; end
        if (ack_en && cnt >= ack_delay) begin mem_ack = 1'b1; got_q.push_back(cur); end
        else cnt++;
      end else begin
        active = 0; cnt = 0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic send_byte(input logic [26:0] a, input logic [7:0] d);
    int n = 0;
    while (ioctl_wait && n < 200) begin tick(); n++; end
    checks++;
    if (n >= 200) begin errors++; $display("FAIL send_wait_timeout got=wait_high exp=wait_low"); end
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [15:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick();
  endtask

  task automatic end_dl();
    int n = 0;
    ioctl_download = 1'b0;
    while (!done && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin errors++; $display("FAIL done_timeout got=done_low exp=done_high"); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({ioctl_wait, mem_req, loading, done, err} !== 5'b0) begin errors++; $display("FAIL reset_flags got=%b exp=00000", {ioctl_wait, mem_req, loading, done, err}); end
    checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    checks++; if (mem_data !== 16'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_data); end
    checks++; if (mem_be !== 2'b0) begin errors++; $display("FAIL reset_be got=%b exp=00", mem_be); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pair();
    got_q.delete(); ack_delay = 0;
    start_dl(16'd0);
    checks++; if (loading !== 1'b1) begin errors++; $display("FAIL pair_loading got=%b exp=1", loading); end
    send_byte(27'd0, 8'h12);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL pair_held_noreq got=%b exp=0", mem_req); end
    send_byte(27'd1, 8'h34);
    checks++; if ({mem_req, ioctl_wait} !== 2'b11) begin errors++; $display("FAIL pair_req_wait got=%b exp=11", {mem_req, ioctl_wait}); end
    checks++; if ({mem_addr, mem_data, mem_be} !== {23'd0, 16'h1234, 2'b11}) begin errors++; $display("FAIL pair_req_fields got=%h/%h/%b exp=0/1234/11", mem_addr, mem_data, mem_be); end
    tick();
    checks++; if ({mem_req, ioctl_wait} !== 2'b00) begin errors++; $display("FAIL pair_after_ack got=%b exp=00", {mem_req, ioctl_wait}); end
    end_dl();
    checks++; if ({done, loading, err} !== 3'b100) begin errors++; $display("FAIL pair_done got=%b exp=100", {done, loading, err}); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL pair_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_split();
    int n = 0;
    bit gap = 0;
    got_q.delete(); ack_delay = 2;
    start_dl(16'd0);
    send_byte(27'd4, 8'hAA);
    send_byte(27'd9, 8'hBB);
    checks++; if ({mem_req, mem_addr, mem_data, mem_be} !== {1'b1, 23'd2, 16'hAA00, 2'b10}) begin errors++; $display("FAIL split_first got=%b/%h/%h/%b exp=1/2/aa00/10", mem_req, mem_addr, mem_data, mem_be); end
    while (got_q.size() < 2 && n < 100) begin
      if (!ioctl_wait) gap = 1;
      tick(); n++;
    end
    checks++; if (gap !== 1'b0) begin errors++; $display("FAIL split_wait_gap got=%b exp=0", gap); end
    end_dl();
    checks++;
    if (got_q.size() !== 2) begin errors++; $display("FAIL split_count got=%0d exp=2", got_q.size()); end
    else if (got_q[1] !== {23'd4, 16'h00BB, 2'b01}) begin errors++; $display("FAIL split_second got=%h exp=%h", got_q[1], {23'd4, 16'h00BB, 2'b01}); end
  endtask

  task automatic test_flush();
    got_q.delete(); ack_delay = 1;
    start_dl(16'd0);
    send_byte(27'd6, 8'h55);
    tick();
    ioctl_download = 1'b0;
    tick();
    checks++; if ({mem_req, ioctl_wait, mem_be} !== 4'b1110) begin errors++; $display("FAIL flush_req got=%b exp=1110", {mem_req, ioctl_wait, mem_be}); end
    end_dl();
    checks++;
    if (got_q.size() !== 1) begin errors++; $display("FAIL flush_count got=%0d exp=1", got_q.size()); end
    else if (got_q[0] !== {23'd3, 16'h5500, 2'b10}) begin errors++; $display("FAIL flush_word got=%h exp=%h", got_q[0], {23'd3, 16'h5500, 2'b10}); end
    checks++; if ({done, loading} !== 2'b10) begin errors++; $display("FAIL flush_done got=%b exp=10", {done, loading}); end
  endtask

  task automatic test_wrong_index();
    got_q.delete(); ack_delay = 0;
    start_dl(16'd1);
    send_byte(27'd0, 8'h01);
    send_byte(27'd1, 8'h02);
    send_byte(27'd6, 8'h03);
    checks++; if (loading !== 1'b0) begin errors++; $display("FAIL wrongidx_loading got=%b exp=0", loading); end
    ioctl_download = 1'b0;
    tick(); tick();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL wrongidx_writes got=%0d exp=0", got_q.size()); end
    checks++; if ({done, err, mem_req} !== 3'b100) begin errors++; $display("FAIL wrongidx_outputs got=%b exp=100", {done, err, mem_req}); end
  endtask

  task automatic test_ack_delay();
    got_q.delete(); ack_delay = 5;
    start_dl(16'd0);
    send_byte(27'h10, 8'h12);
    send_byte(27'h11, 8'h34);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({mem_req, ioctl_wait, mem_addr, mem_data, mem_be} !== {2'b11, 23'd8, 16'h1234, 2'b11}) begin
        errors++; $display("FAIL ackdly_stable cyc=%0d got=%b%b/%h/%h/%b exp=11/8/1234/11", i, mem_req, ioctl_wait, mem_addr, mem_data, mem_be);
      end
      if (i == 1) begin ioctl_addr = 27'h20; ioctl_data = 8'h99; ioctl_wr = 1'b1; end
      if (i == 2) ioctl_wr = 1'b0;
      tick();
    end
    end_dl();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL ackdly_err got=%b exp=1", err); end
    checks++;
    if (got_q.size() !== 1) begin errors++; $display("FAIL ackdly_count got=%0d exp=1", got_q.size()); end
    else if (got_q[0] !== {23'd8, 16'h1234, 2'b11}) begin errors++; $display("FAIL ackdly_word got=%h exp=%h", got_q[0], {23'd8, 16'h1234, 2'b11}); end
  endtask

  task automatic test_range();
    got_q.delete(); ack_delay = 0;
    start_dl(16'd0);
    checks++; if ({err, done} !== 2'b00) begin errors++; $display("FAIL range_start_clear got=%b exp=00", {err, done}); end
    send_byte(27'h1000000, 8'h77);
    checks++; if ({mem_req, err} !== 2'b01) begin errors++; $display("FAIL range_drop got=%b exp=01", {mem_req, err}); end
    send_byte(27'hFFFFFF, 8'h66);
    checks++; if ({mem_req, mem_addr, mem_data, mem_be} !== {1'b1, 23'h7FFFFF, 16'h0066, 2'b01}) begin errors++; $display("FAIL range_top got=%b/%h/%h/%b exp=1/7fffff/0066/01", mem_req, mem_addr, mem_data, mem_be); end
    end_dl();
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL range_count got=%0d exp=1", got_q.size()); end
  endtask

  task automatic test_reset_mid();
    got_q.delete(); ack_en = 1'b0;
    start_dl(16'd0);
    send_byte(27'h40, 8'h01);
    send_byte(27'h41, 8'h02);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rstmid_req got=%b exp=1", mem_req); end
    rst = 1'b1;
    tick();
    checks++;
    if ({ioctl_wait, mem_req, loading, done, err, mem_addr, mem_data, mem_be} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got=%b%b%b%b%b/%h/%h/%b exp=all0", ioctl_wait, mem_req, loading, done, err, mem_addr, mem_data, mem_be);
    end
    rst = 1'b0; ack_en = 1'b1; ack_delay = 0; ioctl_download = 1'b0;
    tick();
    start_dl(16'd0);
    send_byte(27'h50, 8'hAA);
    rst = 1'b1; ioctl_download = 1'b0;
    tick();
    rst = 1'b0;
    got_q.delete();
    start_dl(16'd0);
    send_byte(27'h53, 8'hBB);
    end_dl();
    checks++;
    if (got_q.size() !== 1) begin errors++; $display("FAIL rstmid_discard_count got=%0d exp=1", got_q.size()); end
    else if (got_q[0] !== {23'h29, 16'h00BB, 2'b01}) begin errors++; $display("FAIL rstmid_discard_word got=%h exp=%h", got_q[0], {23'h29, 16'h00BB, 2'b01}); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [26:0] ba[$];
      logic [7:0]  bd[$];
      wr_t         exp_q[$];
      int          nitems, base, prev_w, w, mode, k;
      got_q.delete();
      ack_delay = $urandom_range(0, 3);
      nitems = $urandom_range(3, 10);
      base = $urandom_range(0, 1 << 20);
      prev_w = -1;
      for (int i = 0; i < nitems; i++) begin
        do w = base + $urandom_range(0, 31); while (w == prev_w);
        prev_w = w;
        mode = $urandom_range(0, 2);
        if (mode != 2) begin ba.push_back(27'(2 * w)); bd.push_back(8'($urandom)); end
        if (mode != 1) begin ba.push_back(27'(2 * w + 1)); bd.push_back(8'($urandom)); end
      end
      // Expected writes: an even byte immediately followed by its odd partner pairs up
      k = 0;
      while (k < ba.size()) begin
        if (ba[k][0] == 1'b0 && k + 1 < ba.size() && ba[k+1] == ba[k] + 27'd1) begin
          exp_q.push_back({ba[k][23:1], bd[k], bd[k+1], 2'b11}); k += 2;
        end else if (ba[k][0] == 1'b0) begin
          exp_q.push_back({ba[k][23:1], bd[k], 8'h00, 2'b10}); k++;
        end else begin
          exp_q.push_back({ba[k][23:1], 8'h00, bd[k], 2'b01}); k++;
        end
      end
      start_dl(16'd0);
      for (int i = 0; i < ba.size(); i++) begin
        send_byte(ba[i], bd[i]);
        repeat ($urandom_range(0, 2)) tick();
      end
      end_dl();
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < exp_q.size(); i++) begin
          checks++;
          if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_word it=%0d idx=%0d got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
        end
      end
      checks++; if ({err, done, loading} !== 3'b010) begin errors++; $display("FAIL rand_status it=%0d got=%b exp=010", it, {err, done, loading}); end
    end
  endtask

  initial begin
    rst = 1'b1; ioctl_download = 1'b0; ioctl_index = 16'd0;
    ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = 8'h00;
    test_reset();
    test_pair();
    test_split();
    test_flush();
    test_wrong_index();
    test_ack_delay();
    test_range();
    test_reset_mid();
    test_random();
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL req_stability got=%0d exp=0", stab_viol); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
